// File: rtl/win_checker.sv
// rtl/win_checker.sv - connect-four board scanner reporting win, draw or game-not-over
//
// Purpose:
//   On request, streams the seven column words of the board RAM into a local
//   copy (one column per cycle, 1-cycle RAM read latency), evaluates every
//   window of four cells in a single cycle, and holds the verdict for as long
//   as the request stays high.
//
// Ports:
//   clk           in   1  rising-edge clock
//   reset         in   1  synchronous reset, active-low
//   logic_go      in   1  check request, held high while waiting for a result
//   cur_player    in   1  player who made the last move; breaks win ties
//   rd_onoff      in   6  occupancy word of the addressed column (bit r = row r)
//   rd_player     in   6  owner word of the addressed column
//   rd_addr       out  3  column read address
//   logic_result  out  3  0 = UNSURE, 1 = OVER, 2 = NOTOVER
//   winner_valid  out  1  OVER was caused by a four-in-a-row
//   winner        out  1  winning player, meaningful when winner_valid = 1

module win_checker #(
   parameter int NUM_COLS = 7,
   parameter int NUM_ROWS = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                logic_go,
   input  logic                cur_player,
   input  logic [NUM_ROWS-1:0] rd_onoff,
   input  logic [NUM_ROWS-1:0] rd_player,
   output logic [2:0]          rd_addr,
   output logic [2:0]          logic_result,
   output logic                winner_valid,
   output logic                winner
);

   localparam int          CELLS    = NUM_COLS * NUM_ROWS;
   localparam int          IDX_W    = $clog2(CELLS);
   localparam logic [2:0]  LAST_COL = 3'(NUM_COLS - 1);

   localparam logic [2:0]  RES_UNSURE  = 3'd0;
   localparam logic [2:0]  RES_OVER    = 3'd1;
   localparam logic [2:0]  RES_NOTOVER = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_EVAL  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t             r_state;
   logic [2:0]         r_col;
   logic [CELLS-1:0]   r_occ;
   logic [CELLS-1:0]   r_own;
   logic [2:0]         r_result;
   logic               r_winner_valid;
   logic               r_winner;

   // w_win[1]: some window is four player-1 cells, w_win[0]: four player-0 cells
   logic [1:0]         w_win;
   logic               w_full;

   // Cell (c, r) lives at bit c*NUM_ROWS + r of the board registers.
   function automatic logic [IDX_W-1:0] cell_idx(input int c, input int r);
      cell_idx = IDX_W'(c * NUM_ROWS + r);
   endfunction

   // Evaluates the window starting at (c, r) stepping by (dc, dr).
   // Returns {player-1 win, player-0 win}; an empty cell never counts,
   // whatever its owner bit holds.
   function automatic logic [1:0] check4(
      input logic [CELLS-1:0] occ,
      input logic [CELLS-1:0] own,
      input int               c,
      input int               r,
      input int               dc,
      input int               dr
   );
      logic [3:0] o;
      logic [3:0] p;
      for (int k = 0; k < 4; k++) begin
         o[k] = occ[cell_idx(c + k * dc, r + k * dr)];
         p[k] = own[cell_idx(c + k * dc, r + k * dr)];
      end
      check4 = {(&o) & (&p), (&o) & ~(|p)};
   endfunction

   always_comb begin
      w_win = 2'b00;
      for (int c = 0; c < NUM_COLS; c++) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            if (c <= NUM_COLS - 4) begin
               w_win = w_win | check4(r_occ, r_own, c, r, 1, 0);
            end
            if (r <= NUM_ROWS - 4) begin
               w_win = w_win | check4(r_occ, r_own, c, r, 0, 1);
            end
            if ((c <= NUM_COLS - 4) && (r <= NUM_ROWS - 4)) begin
               w_win = w_win | check4(r_occ, r_own, c, r, 1, 1);
            end
            if ((c <= NUM_COLS - 4) && (r >= 3)) begin
               w_win = w_win | check4(r_occ, r_own, c, r, 1, -1);
            end
         end
      end
   end

   assign w_full = &r_occ;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= ST_IDLE;
         r_col          <= '0;
         r_occ          <= '0;
         r_own          <= '0;
         r_result       <= RES_UNSURE;
         r_winner_valid <= 1'b0;
         r_winner       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_col          <= '0;
               r_result       <= RES_UNSURE;
               r_winner_valid <= 1'b0;
               r_winner       <= 1'b0;
               if (logic_go) begin
                  r_state <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               if (!logic_go) begin
                  r_state <= ST_IDLE;
                  r_col   <= '0;
               end else begin
                  // Data on the read port belongs to the previous address, so
                  // nothing is valid yet in the first LOAD cycle. Columns are
                  // shifted in from the top so column 0 ends up at bits [5:0]
                  // after all seven captures, overwriting the whole board.
                  if (r_col != 3'd0) begin
                     r_occ <= {rd_onoff, r_occ[CELLS-1:NUM_ROWS]};
                     r_own <= {rd_player, r_own[CELLS-1:NUM_ROWS]};
                  end
                  if (r_col == LAST_COL) begin
                     r_state <= ST_FLUSH;
                  end else begin
                     r_col <= r_col + 3'd1;
                  end
               end
            end

            ST_FLUSH: begin
               if (!logic_go) begin
                  r_state <= ST_IDLE;
                  r_col   <= '0;
               end else begin
                  // Last column's data arrives here while rd_addr still holds it.
                  r_occ   <= {rd_onoff, r_occ[CELLS-1:NUM_ROWS]};
                  r_own   <= {rd_player, r_own[CELLS-1:NUM_ROWS]};
                  r_col   <= '0;
                  r_state <= ST_EVAL;
               end
            end

            ST_EVAL: begin
               if (!logic_go) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_DONE;
                  if (w_win != 2'b00) begin
                     // A win beats a full board; simultaneous wins go to the
                     // player who just moved.
                     r_result       <= RES_OVER;
                     r_winner_valid <= 1'b1;
                     r_winner       <= (w_win == 2'b11) ? cur_player : w_win[1];
                  end else if (w_full) begin
                     r_result       <= RES_OVER;
                     r_winner_valid <= 1'b0;
                     r_winner       <= 1'b0;
                  end else begin
                     r_result       <= RES_NOTOVER;
                     r_winner_valid <= 1'b0;
                     r_winner       <= 1'b0;
                  end
               end
            end

            ST_DONE: begin
               if (!logic_go) begin
                  r_state        <= ST_IDLE;
                  r_result       <= RES_UNSURE;
                  r_winner_valid <= 1'b0;
                  r_winner       <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd_addr      = r_col;
   assign logic_result = r_result;
   assign winner_valid = r_winner_valid;
   assign winner       = r_winner;

endmodule

// File: tb/tb_win_checker.sv
// tb/tb_win_checker.sv - self-checking bench for win_checker

module tb_win_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       logic_go;
   logic       cur_player;
   logic [5:0] rd_onoff;
   logic [5:0] rd_player;
   logic [2:0] rd_addr;
   logic [2:0] logic_result;
   logic       winner_valid;
   logic       winner;

   int errors = 0;
   int checks = 0;

   logic [5:0] mem_on [0:7];
   logic [5:0] mem_pl [0:7];

   typedef struct {
      logic [41:0] on;
      logic [41:0] pl;
      logic        cur;
      int          res;
      int          val;
      int          win;
   } vec_t;

   vec_t vecs [14];

   win_checker dut (
      .clk          (clk),
      .reset        (reset),
      .logic_go     (logic_go),
      .cur_player   (cur_player),
      .rd_onoff     (rd_onoff),
      .rd_player    (rd_player),
      .rd_addr      (rd_addr),
      .logic_result (logic_result),
      .winner_valid (winner_valid),
      .winner       (winner)
   );

   always #5 clk = ~clk;

   // Board RAM with one cycle of read latency.
   always @(posedge clk) begin
      rd_onoff  <= mem_on[rd_addr];
      rd_player <= mem_pl[rd_addr];
   end

   function automatic vec_t mk(input logic [41:0] on, input logic [41:0] pl,
                               input logic cur, input int res, input int val, input int win);
      vec_t v;
      v.on  = on;
      v.pl  = pl;
      v.cur = cur;
      v.res = res;
      v.val = val;
      v.win = win;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic load_mem(input vec_t v);
      for (int c = 0; c < 7; c++) begin
         mem_on[c] = v.on[c*6 +: 6];
         mem_pl[c] = v.pl[c*6 +: 6];
      end
      mem_on[7] = 6'h00;
      mem_pl[7] = 6'h00;
      cur_player = v.cur;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Raises logic_go and follows the scan; edge 0 is the one that samples
   // logic_go in IDLE, so the result must first appear after edge 9.
   task automatic do_request(input string tag, input vec_t v, input bit hold);
      int lat;
      int addr_ok;
      lat     = -1;
      addr_ok = 1;
      logic_go = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (k <= 6 && rd_addr != 3'(k)) addr_ok = 0;
         if (k == 7 && rd_addr != 3'd6) addr_ok = 0;
         if (logic_result != 3'd0) begin
            lat = k;
            break;
         end
      end
      chk({tag, "_latency"}, lat, 9);
      chk({tag, "_addr_seq"}, addr_ok, 1);
      chk({tag, "_result"}, int'(logic_result), v.res);
      chk({tag, "_winner_valid"}, int'(winner_valid), v.val);
      if (v.val == 1) chk({tag, "_winner"}, int'(winner), v.win);
      if (!hold) begin
         logic_go = 1'b0;
         step();
         chk({tag, "_idle_result"}, int'(logic_result), 0);
         chk({tag, "_idle_valid"}, int'(winner_valid), 0);
      end
   endtask

   initial begin
      int ok;

      // Columns listed {c6, c5, c4, c3, c2, c1, c0}.
      vecs[0]  = mk(42'h0, 42'h0, 1'b0, 2, 0, 0);
      vecs[1]  = mk({6'h00,6'h00,6'h00,6'h0F,6'h00,6'h00,6'h00},
                    {6'h00,6'h00,6'h00,6'h0F,6'h00,6'h00,6'h00}, 1'b0, 1, 1, 1);
      vecs[2]  = mk({6'h00,6'h00,6'h00,6'h01,6'h01,6'h01,6'h01},
                    42'h0, 1'b1, 1, 1, 0);
      vecs[3]  = mk({6'h00,6'h00,6'h00,6'h0F,6'h07,6'h03,6'h01},
                    {6'h00,6'h00,6'h00,6'h08,6'h04,6'h02,6'h01}, 1'b0, 1, 1, 1);
      vecs[4]  = mk({7{6'h3F}},
                    {6'h0C,6'h33,6'h0C,6'h33,6'h0C,6'h33,6'h0C}, 1'b0, 1, 0, 0);
      vecs[5]  = mk({6'h00,6'h00,6'h00,6'h00,6'h0F,6'h00,6'h0F},
                    {6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h0F}, 1'b0, 1, 1, 0);
      vecs[6]  = mk({6'h00,6'h00,6'h00,6'h00,6'h0F,6'h00,6'h0F},
                    {6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h0F}, 1'b1, 1, 1, 1);
      vecs[7]  = mk({7{6'h3F}},
                    {6'h0C,6'h33,6'h0C,6'h33,6'h0C,6'h33,6'h0F}, 1'b0, 1, 1, 1);
      vecs[8]  = mk({6'h01,6'h01,6'h01,6'h01,6'h00,6'h00,6'h00},
                    {6'h01,6'h01,6'h01,6'h01,6'h00,6'h00,6'h00}, 1'b0, 1, 1, 1);
      vecs[9]  = mk({6'h01,6'h03,6'h07,6'h0F,6'h00,6'h00,6'h00},
                    {6'h00,6'h01,6'h03,6'h07,6'h00,6'h00,6'h00}, 1'b1, 1, 1, 0);
      vecs[10] = mk({6'h00,6'h00,6'h00,6'h00,6'h01,6'h01,6'h01},
                    {6'h00,6'h00,6'h00,6'h00,6'h01,6'h01,6'h01}, 1'b0, 2, 0, 0);
      vecs[11] = mk({6'h00,6'h00,6'h00,6'h01,6'h01,6'h01,6'h01},
                    {6'h00,6'h00,6'h00,6'h00,6'h00,6'h01,6'h00}, 1'b0, 2, 0, 0);
      vecs[12] = mk({6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h07},
                    {7{6'h3F}}, 1'b0, 2, 0, 0);
      vecs[13] = mk({6'h3C,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00},
                    {6'h3C,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00}, 1'b0, 1, 1, 1);

      reset      = 1'b0;
      logic_go   = 1'b0;
      cur_player = 1'b0;
      load_mem(vecs[0]);
      step();
      step();
      chk("reset_rd_addr", int'(rd_addr), 0);
      chk("reset_result", int'(logic_result), 0);
      chk("reset_winner_valid", int'(winner_valid), 0);
      chk("reset_winner", int'(winner), 0);
      reset = 1'b1;
      step();

      for (int i = 0; i < 14; i++) begin
         load_mem(vecs[i]);
         do_request($sformatf("vec%0d", i), vecs[i], 1'b0);
      end

      // Abort in the 4th LOAD cycle, then a full rescan.
      load_mem(vecs[3]);
      logic_go = 1'b1;
      for (int k = 0; k < 4; k++) step();
      chk("abort_addr_before", int'(rd_addr), 3);
      logic_go = 1'b0;
      step();
      chk("abort_addr_idle", int'(rd_addr), 0);
      chk("abort_result", int'(logic_result), 0);
      ok = 1;
      for (int k = 0; k < 10; k++) begin
         step();
         if (logic_result != 3'd0) ok = 0;
      end
      chk("abort_no_result", ok, 1);
      do_request("rescan", vecs[3], 1'b0);

      // Hold in DONE, then reset back to IDLE.
      load_mem(vecs[1]);
      do_request("hold", vecs[1], 1'b1);
      ok = 1;
      for (int k = 0; k < 5; k++) begin
         step();
         if (logic_result != 3'd1 || winner_valid != 1'b1 || winner != 1'b1) ok = 0;
      end
      chk("hold_stable", ok, 1);
      reset = 1'b0;
      step();
      chk("hold_reset_rd_addr", int'(rd_addr), 0);
      chk("hold_reset_result", int'(logic_result), 0);
      chk("hold_reset_valid", int'(winner_valid), 0);
      chk("hold_reset_winner", int'(winner), 0);
      reset = 1'b1;
      do_request("after_reset", vecs[1], 1'b0);

      // Reset mid-scan while logic_go stays high.
      load_mem(vecs[9]);
      logic_go = 1'b1;
      for (int k = 0; k < 3; k++) step();
      reset = 1'b0;
      ok = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         if (rd_addr != 3'd0 || logic_result != 3'd0) ok = 0;
      end
      chk("reset_priority", ok, 1);
      reset = 1'b1;
      do_request("post_midscan", vecs[9], 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
